image_streamer: RTL and testbench
=================================

Name: image_streamer

Overview:
- Transmit-side partner of the convolution window buffer.
- Captures one ImageWidth x ImageHeight feature map, pixel by pixel, into internal registers.
- On command, streams the map back out in raster order over a valid/ready pixel interface, which drives the window buffer's in_valid/in_data, gated by its out_ready.
- The retained image can be re-streamed any number of times, so one input map can feed successive kernels without reloading.

Parameters:
- BitSize, 32, width of one pixel word
- ImageWidth, 4, pixels per row
- ImageHeight, 4, rows per image (default equals ImageWidth; square maps)

Ports:
- clk  input  1  single clock, rising edge
- res  input  1  reset; synchronous, active-high
- wr_valid  input  1  load-side pixel valid
- wr_data  input  BitSize  load-side pixel, raster order (row 0 col 0 first)
- wr_ready  output  1  block accepts a load pixel this cycle
- start  input  1  begin streaming the stored image (honoured only in FULL)
- clear  input  1  discard image, return to LOAD
- in_ready  input  1  downstream can accept a pixel this cycle
- out_valid  output  1  out_data holds a valid pixel
- out_data  output  BitSize  streamed pixel
- out_row_end  output  1  qualifies out_data as last pixel of a row (col == ImageWidth-1)
- out_done  output  1  one-cycle pulse, cycle after final pixel transfer
- full  output  1  complete image stored (state FULL or STREAM)

Behaviour:
- Clocking and reset:
  - One clock (clk); reset (res) is synchronous and active-high.
  - Reset state: LOAD, wr_ptr=0, rd_ptr=0.
  - Outputs under reset: wr_ready=1, out_valid=0, out_data=0, out_row_end=0, out_done=0, full=0.
  - Pixel storage is not cleared.
- Storage and counters:
  - Storage: ImageWidth*ImageHeight words of BitSize.
  - Pointers: $clog2(ImageWidth*ImageHeight) bits (min 1).
  - col/row counters: $clog2(ImageWidth) and $clog2(ImageHeight) bits (min 1 each).
- State LOAD:
  - wr_ready=1.
  - Write on wr_valid&&wr_ready: mem[wr_ptr] <= wr_data, wr_ptr++.
  - Write at wr_ptr==last: next state FULL, wr_ptr returns to 0.
  - start ignored in LOAD.
- State FULL:
  - wr_ready=0, full=1, out_valid=0; wr_valid ignored.
  - start=1 -> STREAM next cycle, with rd_ptr=0, col=0, row=0.
- State STREAM:
  - out_valid=1.
  - out_data = mem[rd_ptr], driven combinationally from storage.
  - out_row_end = (col==ImageWidth-1).
  - Transfer on out_valid&&in_ready: rd_ptr++, col wraps at ImageWidth-1 and increments row.
  - When in_ready=0: out_data and out_row_end hold stable.
  - Transfer at rd_ptr==last: next state FULL, rd_ptr=0; out_done=1 in the following cycle only.
- Latency:
  - start sampled at edge t -> first pixel valid in cycle t+1.
  - With in_ready held 1: N=ImageWidth*ImageHeight pixels in N consecutive cycles.
  - out_done in cycle t+N+1, then FULL.
  - start asserted in the cycle out_done is high is accepted: next stream begins the cycle after.
- clear:
  - Any state; highest priority after res.
  - Next cycle: LOAD, wr_ptr=0, rd_ptr=0, out_valid=0, no out_done pulse.
  - A clear coincident with a write in LOAD drops that write.
  - A clear coincident with the final stream transfer suppresses out_done.
- start and clear together: clear wins.
- start outside FULL: ignored, no latching.
- Reset mid-operation: identical to clear (aborts load or stream).
- ImageWidth=1 and/or ImageHeight=1 legal:
  - out_row_end permanently 1 when ImageWidth=1.
  - Single-pixel image streams in one cycle.

Test Plan:
- Basic load and stream:
  - res, then load 1..16 (4x4, wr_valid always 1) -> wr_ready low from cycle 17, full=1.
  - start -> out_data 1..16 on 16 consecutive cycles.
  - out_row_end on 4,8,12,16.
  - out_done single pulse on cycle after 16.
- Backpressure:
  - in_ready toggles 1,0,0,1,... during stream -> each pixel held stable while in_ready=0.
  - Sequence still 1..16 with no duplicates or drops; out_done only after 16th transfer.
- Re-stream:
  - After done, assert start again (also once coincident with out_done) -> identical 1..16 stream.
  - wr_valid with data 0xFF in FULL -> ignored, stored image unchanged.
- Abort with clear:
  - clear after 5th transfer -> out_valid=0 next cycle, no out_done, wr_ready=1.
  - Reload 101..116, start -> stream 101..116.
- Reset mid-load:
  - res after 7 writes, then load 16 new pixels -> full only after 16 new writes; stream matches new data.
- Degenerate sizes and control conflicts:
  - ImageWidth=1, ImageHeight=1 -> one write sets full; start yields one out_valid cycle with out_row_end=1, out_done next.
  - start+clear together -> LOAD.

Source files
------------

// File: rtl/image_streamer.sv
// Holds one feature map loaded in raster order and replays it on a valid/ready pixel stream.
// The retained image can be streamed any number of times until it is cleared or reset.
module image_streamer #(
   parameter int BitSize     = 32,
   parameter int ImageWidth  = 4,
   parameter int ImageHeight = ImageWidth
) (
   input  logic               clk,
   input  logic               res,
   input  logic               wr_valid,
   input  logic [BitSize-1:0] wr_data,
   output logic               wr_ready,
   input  logic               start,
   input  logic               clear,
   input  logic               in_ready,
   output logic               out_valid,
   output logic [BitSize-1:0] out_data,
   output logic               out_row_end,
   output logic               out_done,
   output logic               full
);

   localparam int Pixels  = ImageWidth * ImageHeight;
   localparam int PtrBits = (Pixels > 1) ? $clog2(Pixels) : 1;
   localparam int ColBits = (ImageWidth > 1) ? $clog2(ImageWidth) : 1;
   localparam int RowBits = (ImageHeight > 1) ? $clog2(ImageHeight) : 1;

   localparam logic [PtrBits-1:0] LastPtr = PtrBits'(Pixels - 1);
   localparam logic [ColBits-1:0] LastCol = ColBits'(ImageWidth - 1);
   localparam logic [RowBits-1:0] LastRow = RowBits'(ImageHeight - 1);

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      FULL   = 2'd1,
      STREAM = 2'd2
   } state_t;

   state_t state, next_state;

   logic [BitSize-1:0] mem [Pixels];
   logic [PtrBits-1:0] wr_ptr, rd_ptr;
   logic [ColBits-1:0] col;
   logic [RowBits-1:0] row;
   logic               done_q;
   logic               wr_fire, rd_fire, rd_last;

   assign rd_last  = (col == LastCol) && (row == LastRow);
   assign out_done = done_q;

   always_ff @(posedge clk) begin
      if (res) begin
         state <= LOAD;
      end else begin
         state <= next_state;
      end
   end

   // clear overrides every transition, so it is applied after the per-state decision
   always_comb begin
      next_state  = state;
      wr_ready    = 1'b0;
      full        = 1'b0;
      out_valid   = 1'b0;
      out_data    = '0;
      out_row_end = 1'b0;
      wr_fire     = 1'b0;
      rd_fire     = 1'b0;
      case (state)
         LOAD: begin
            wr_ready = 1'b1;
            wr_fire  = wr_valid;
            if (wr_fire && (wr_ptr == LastPtr)) begin
               next_state = FULL;
            end
         end
         FULL: begin
            full = 1'b1;
            if (start) begin
               next_state = STREAM;
            end
         end
         STREAM: begin
            full        = 1'b1;
            out_valid   = 1'b1;
            out_data    = mem[rd_ptr];
            out_row_end = (col == LastCol);
            rd_fire     = in_ready;
            if (rd_fire && rd_last) begin
               next_state = FULL;
            end
         end
         default: begin
            next_state = LOAD;
         end
      endcase
      if (clear) begin
         next_state = LOAD;
      end
   end

   // Storage is deliberately left out of reset; a clear or reset only drops the pending write
   always_ff @(posedge clk) begin
      if (wr_fire && !clear && !res) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (res || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         col    <= '0;
         row    <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= rd_fire && rd_last;
         if (wr_fire) begin
            wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
         end
         if ((state == FULL) && start) begin
            rd_ptr <= '0;
            col    <= '0;
            row    <= '0;
         end else if (rd_fire) begin
            rd_ptr <= rd_last ? '0 : rd_ptr + 1'b1;
            if (col == LastCol) begin
               col <= '0;
               row <= (row == LastRow) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_image_streamer.sv
// Self-checking bench: a vector table on a 1x1 instance, then directed and random traffic on a
// 4x4 instance compared every cycle against a transaction-level image model.
module tb_image_streamer;

   localparam int W = 4;
   localparam int H = 4;
   localparam int N = W * H;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 4x4 instance
   logic        res = 1'b1, clear = 1'b0, start = 1'b0, wr_valid = 1'b0, in_ready = 1'b0;
   logic [31:0] wr_data = '0;
   logic        wr_ready, out_valid, out_row_end, out_done, full;
   logic [31:0] out_data;

   image_streamer #(.BitSize(32), .ImageWidth(W), .ImageHeight(H)) dut (
      .clk(clk), .res(res), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .start(start), .clear(clear), .in_ready(in_ready), .out_valid(out_valid),
      .out_data(out_data), .out_row_end(out_row_end), .out_done(out_done), .full(full)
   );

   // 1x1 instance
   logic       s_res = 1'b1, s_clear = 1'b0, s_start = 1'b0, s_wr_valid = 1'b0, s_in_ready = 1'b0;
   logic [7:0] s_wr_data = '0;
   logic       s_wr_ready, s_out_valid, s_out_row_end, s_out_done, s_full;
   logic [7:0] s_out_data;

   image_streamer #(.BitSize(8), .ImageWidth(1), .ImageHeight(1)) dut1 (
      .clk(clk), .res(s_res), .wr_valid(s_wr_valid), .wr_data(s_wr_data), .wr_ready(s_wr_ready),
      .start(s_start), .clear(s_clear), .in_ready(s_in_ready), .out_valid(s_out_valid),
      .out_data(s_out_data), .out_row_end(s_out_row_end), .out_done(s_out_done), .full(s_full)
   );

   typedef struct {
      logic       res, clear, start, wr_valid;
      logic [7:0] wr_data;
      logic       in_ready;
      logic [12:0] exp;
   } vec_t;

   vec_t tbl[18];

   function automatic vec_t mk(input logic r, input logic c, input logic s, input logic wv,
                               input logic [7:0] wd, input logic ir, input logic e_wr,
                               input logic e_full, input logic e_ov, input logic e_re,
                               input logic e_dn, input logic [7:0] e_data);
      vec_t v;
      v.res = r; v.clear = c; v.start = s; v.wr_valid = wv; v.wr_data = wd; v.in_ready = ir;
      v.exp = {e_wr, e_full, e_ov, e_re, e_dn, e_data};
      return v;
   endfunction

   // Model: phase 0 = loading, 1 = image held, 2 = streaming
   int          m_phase = 0;
   int          m_cnt   = 0;
   int          m_idx   = 0;
   logic        m_done  = 1'b0;
   logic [31:0] m_img[N];
   logic [31:0] got_q[$];
   int          cyc = 0;

   task automatic checkOutput();
      logic [36:0] act, exp;
      logic [31:0] e_data;
      e_data = (m_phase == 2) ? m_img[m_idx] : 32'd0;
      exp = {m_phase == 0, m_phase != 0, m_phase == 2,
             (m_phase == 2) && ((m_idx % W) == W - 1), m_done, e_data};
      act = {wr_ready, full, out_valid, out_row_end, out_done, out_data};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL outputs cyc=%0d got {wr_ready,full,valid,row_end,done}=%b data=%h expected %b data=%h",
                  cyc, act[36:32], act[31:0], exp[36:32], exp[31:0]);
      end
   endtask

   task automatic modelStep(input logic r, input logic c, input logic s, input logic wv,
                            input logic [31:0] wd, input logic ir);
      logic done_next = 1'b0;
      if (r || c) begin
         m_phase = 0; m_cnt = 0; m_idx = 0;
      end else if (m_phase == 0) begin
         if (wv) begin
            m_img[m_cnt] = wd;
            m_cnt++;
            if (m_cnt == N) begin m_phase = 1; m_cnt = 0; end
         end
      end else if (m_phase == 1) begin
         if (s) begin m_phase = 2; m_idx = 0; end
      end else if (ir) begin
         m_idx++;
         if (m_idx == N) begin m_phase = 1; m_idx = 0; done_next = 1'b1; end
      end
      m_done = done_next;
   endtask

   task automatic applyStimulus(input logic r, input logic c, input logic s, input logic wv,
                                input logic [31:0] wd, input logic ir);
      @(negedge clk);
      res = r; clear = c; start = s; wr_valid = wv; wr_data = wd; in_ready = ir;
      #1;
      checkOutput();
      if (out_valid && ir) got_q.push_back(out_data);
      modelStep(r, c, s, wv, wd, ir);
      cyc++;
   endtask

   task automatic checkStream(input int base);
      checks++;
      if (got_q.size() != N) begin
         errors++;
         $display("[TB] FAIL stream_len got %0d expected %0d", got_q.size(), N);
      end else begin
         for (int i = 0; i < N; i++) begin
            checks++;
            if (got_q[i] !== 32'(base + i)) begin
               errors++;
               $display("[TB] FAIL stream[%0d] got %0d expected %0d", i, got_q[i], base + i);
            end
         end
      end
   endtask

   task automatic loadSeq(input int base);
      for (int i = 0; i < N; i++) applyStimulus(0, 0, 0, 1, 32'(base + i), 0);
   endtask

   initial begin
      tbl[0]  = mk(1,0,0,0,8'h00,0, 1,0,0,0,0,8'h00);
      tbl[1]  = mk(0,0,0,1,8'hA5,0, 0,1,0,0,0,8'h00);
      tbl[2]  = mk(0,0,0,1,8'hFF,0, 0,1,0,0,0,8'h00);
      tbl[3]  = mk(0,0,1,0,8'h00,0, 0,1,1,1,0,8'hA5);
      tbl[4]  = mk(0,0,0,0,8'h00,0, 0,1,1,1,0,8'hA5);
      tbl[5]  = mk(0,0,0,0,8'h00,1, 0,1,0,0,1,8'h00);
      tbl[6]  = mk(0,0,1,0,8'h00,1, 0,1,1,1,0,8'hA5);
      tbl[7]  = mk(0,0,0,0,8'h00,1, 0,1,0,0,1,8'h00);
      tbl[8]  = mk(0,1,1,0,8'h00,0, 1,0,0,0,0,8'h00);
      tbl[9]  = mk(0,1,0,1,8'h3C,0, 1,0,0,0,0,8'h00);
      tbl[10] = mk(0,0,0,1,8'h77,0, 0,1,0,0,0,8'h00);
      tbl[11] = mk(0,0,1,0,8'h00,0, 0,1,1,1,0,8'h77);
      tbl[12] = mk(0,1,0,0,8'h00,1, 1,0,0,0,0,8'h00);
      tbl[13] = mk(1,0,0,1,8'h99,0, 1,0,0,0,0,8'h00);
      tbl[14] = mk(0,0,0,1,8'h42,0, 0,1,0,0,0,8'h00);
      tbl[15] = mk(0,0,1,0,8'h00,0, 0,1,1,1,0,8'h42);
      tbl[16] = mk(0,0,0,0,8'h00,1, 0,1,0,0,1,8'h00);
      tbl[17] = mk(0,0,0,0,8'h00,0, 0,1,0,0,0,8'h00);

      // 1x1 vectors: inputs applied before an edge, outputs checked just after it
      for (int i = 0; i < 18; i++) begin
         logic [12:0] act;
         @(negedge clk);
         s_res = tbl[i].res; s_clear = tbl[i].clear; s_start = tbl[i].start;
         s_wr_valid = tbl[i].wr_valid; s_wr_data = tbl[i].wr_data; s_in_ready = tbl[i].in_ready;
         @(posedge clk);
         #1;
         act = {s_wr_ready, s_full, s_out_valid, s_out_row_end, s_out_done, s_out_data};
         checks++;
         if (act !== tbl[i].exp) begin
            errors++;
            $display("[TB] FAIL vec1x1[%0d] got %b_%h expected %b_%h",
                     i, act[12:8], act[7:0], tbl[i].exp[12:8], tbl[i].exp[7:0]);
         end
      end

      // 4x4 has been held in reset during the table; the model starts in reset state
      applyStimulus(1, 0, 0, 0, 0, 0);

      $display("[TB] basic load and stream");
      loadSeq(1);
      applyStimulus(0, 0, 0, 1, 32'hFF, 0);
      applyStimulus(0, 0, 0, 1, 32'hFF, 0);
      got_q.delete();
      applyStimulus(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < N + 2; i++) applyStimulus(0, 0, 0, 0, 0, 1);
      checkStream(1);

      $display("[TB] backpressure");
      got_q.delete();
      applyStimulus(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 2 * N + 4; i++) applyStimulus(0, 0, 0, 0, 0, ((i % 4) == 0) || ((i % 4) == 3));
      checkStream(1);

      $display("[TB] re-stream with start on done");
      got_q.delete();
      applyStimulus(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < N; i++) applyStimulus(0, 0, 0, 0, 0, 1);
      checkStream(1);
      got_q.delete();
      applyStimulus(0, 0, 1, 0, 0, 1);
      for (int i = 0; i < N + 2; i++) applyStimulus(0, 0, 0, 0, 0, 1);
      checkStream(1);

      $display("[TB] abort with clear");
      applyStimulus(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      loadSeq(101);
      got_q.delete();
      applyStimulus(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < N + 2; i++) applyStimulus(0, 0, 0, 0, 0, 1);
      checkStream(101);

      $display("[TB] reset mid-load");
      applyStimulus(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 1, 32'(201 + i), 0);
      applyStimulus(1, 0, 0, 1, 32'd999, 0);
      loadSeq(301);
      got_q.delete();
      applyStimulus(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < N + 2; i++) applyStimulus(0, 0, 0, 0, 0, 1);
      checkStream(301);

      $display("[TB] start with clear");
      applyStimulus(0, 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 1);

      $display("[TB] random traffic");
      for (int i = 0; i < 900; i++) begin
         applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 79) == 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                       $urandom, $urandom_range(0, 2) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
